// File: rtl/vram_bus_arbiter_if.sv
// Bus bundle between the CPU / scan-out requesters, the VRAM arbiter and the RAM.
// The arbiter connects through the slave modport; the requester/RAM side uses master.
interface vram_bus_arbiter_if #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int VID_IW = 6
);
  logic              cpu_req;
  logic              cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DW-1:0]     cpu_rdata;

  logic              vid_req;
  logic [VID_IW-1:0] vid_idx;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DW-1:0]     vid_rdata;

  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_req, vid_idx,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output vid_gnt, vid_rvalid, vid_rdata,
    output mem_addr, mem_we, mem_wdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_req, vid_idx,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  vid_gnt, vid_rvalid, vid_rdata,
    input  mem_addr, mem_we, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/vram_bus_arbiter.sv
// Single-port VRAM arbiter: one access per clock shared between the CPU and the
// video scan-out reader, with a starvation guard and tagged read-data return.
module vram_bus_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int VID_BASE   = 128,
  parameter int VID_IW     = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  vram_bus_arbiter_if.slave    bus
);

  localparam int SW = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VID  = 2'd2
  } tag_e;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v >= SW'(STARVE_MAX)) return SW'(STARVE_MAX);
    return v + SW'(1);
  endfunction

  // Video index is an offset into the video window; the sum wraps at 2**AW.
  function automatic logic [AW-1:0] vid_addr(input logic [VID_IW-1:0] idx);
    return AW'(VID_BASE) + AW'(idx);
  endfunction

  logic          cpu_gnt;
  logic          vid_gnt;

  logic [SW-1:0] starve_q, starve_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  tag_e          tag_p0_q, tag_p0_d;
  tag_e          tag_p1_q, tag_p1_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] vid_rdata_q, vid_rdata_d;

  logic          cpu_rvalid;
  logic          vid_rvalid;

  // Arbitration: video wins contention until the CPU has waited STARVE_MAX grants.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    if (!reset) begin
      if (bus.cpu_req && (!bus.vid_req || starve_q == SW'(STARVE_MAX))) begin
        cpu_gnt = 1'b1;
      end else if (bus.vid_req) begin
        vid_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.cpu_req || cpu_gnt) begin
      starve_d = '0;
    end else if (vid_gnt) begin
      starve_d = sat_inc(starve_q);
    end
  end

  // Issue stage (p0): winner's access registered toward the RAM.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    tag_p0_d    = TAG_NONE;
    if (cpu_gnt) begin
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
      mem_we_d    = bus.cpu_we;
      tag_p0_d    = bus.cpu_we ? TAG_NONE : TAG_CPU;
    end else if (vid_gnt) begin
      mem_addr_d  = vid_addr(bus.vid_idx);
      tag_p0_d    = TAG_VID;
    end
  end

  // Return stage (p1): RAM data arrives now and is steered by the tag.
  always_comb begin
    tag_p1_d    = tag_p0_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    if (cpu_rvalid) cpu_rdata_d = bus.mem_rdata;
    if (vid_rvalid) vid_rdata_d = bus.mem_rdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      tag_p0_q    <= TAG_NONE;
      tag_p1_q    <= TAG_NONE;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      tag_p0_q    <= tag_p0_d;
      tag_p1_q    <= tag_p1_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign cpu_rvalid = (tag_p1_q == TAG_CPU);
  assign vid_rvalid = (tag_p1_q == TAG_VID);

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vid_gnt    = vid_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.vid_rvalid = vid_rvalid;
  assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : cpu_rdata_q;
  assign bus.vid_rdata  = vid_rvalid ? bus.mem_rdata : vid_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = cpu_gnt | vid_gnt | (tag_p0_q != TAG_NONE) | (tag_p1_q != TAG_NONE);

  a_one_grant : assert property (@(posedge clock) disable iff (reset) !(cpu_gnt && vid_gnt));
  a_starve_bound : assert property (@(posedge clock) disable iff (reset)
                                    starve_q <= SW'(STARVE_MAX));

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Directed bench for vram_bus_arbiter: vector table for arbitration/issue/return
// ordering plus hand sequences for reset, data return, write-then-read and mid-op reset.
module tb_vram_bus_arbiter;

  logic clock;
  logic reset;

  vram_bus_arbiter_if #(.AW(8), .DW(8), .VID_IW(6)) bus ();

  vram_bus_arbiter #(
    .AW(8), .DW(8), .VID_BASE(128), .VID_IW(6), .STARVE_MAX(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: read data appears the cycle after the address.
  logic [7:0] ram [256];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
      ram[8'h05] <= 8'h3C;
      ram[8'h83] <= 8'h71;
      ram[8'h81] <= 8'h11;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [7:0] caddr,
                       input logic [7:0] cwdata, input logic vreq, input logic [5:0] vidx);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwdata;
    bus.vid_req   = vreq;
    bus.vid_idx   = vidx;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       creq;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cwdata;
    logic       vreq;
    logic [5:0] vidx;
    logic       egc;
    logic       egv;
    logic       ecrv;
    logic       evrv;
    logic [7:0] eaddr;
    logic       ewe;
  } vec_t;

  vec_t vecs [18];

  initial begin
    // creq cwe caddr cwdata vreq vidx | gnt c/v | rvalid c/v (this cycle) | next mem_addr, mem_we
    vecs = '{
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'h82, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'h82, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b0, 1'b1, 1'b0, 1'b1, 8'h82, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b0, 1'b1, 1'b0, 1'b1, 8'h82, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b0, 1'b1, 1'b0, 1'b1, 8'h82, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b0, 1'b1, 1'b1, 1'b0, 8'h82, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b0, 1'b1, 1'b0, 1'b1, 8'h82, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b0, 1'b1, 1'b0, 1'b1, 8'h82, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd2,  1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0},
      '{1'b1, 1'b1, 8'h20, 8'h99, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 1'b1},
      '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0},
      '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 6'd63, 1'b0, 1'b1, 1'b0, 1'b0, 8'hBF, 1'b0},
      '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 6'd5,  1'b0, 1'b1, 1'b0, 1'b0, 8'h85, 1'b0},
      '{1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0},
      '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0},
      '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0},
      '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0}
    };

    // Reset held with both requesters asking
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 6'd0);
    repeat (3) next_cycle();
    #2;
    chk("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
    chk("rst_vid_gnt",    32'(bus.vid_gnt),    32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0);
    reset = 1'b0;
    next_cycle();

    // CPU read of 0x05
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 6'd0);
    chk("cr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("cr_vid_gnt", 32'(bus.vid_gnt), 32'd0);
    chk("cr_busy_n",  32'(bus.busy),    32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0);
    chk("cr_mem_addr", 32'(bus.mem_addr),   32'h05);
    chk("cr_mem_we",   32'(bus.mem_we),     32'd0);
    chk("cr_rv_n1",    32'(bus.cpu_rvalid), 32'd0);
    chk("cr_busy_n1",  32'(bus.busy),       32'd1);
    next_cycle();
    chk("cr_rv_n2",    32'(bus.cpu_rvalid), 32'd1);
    chk("cr_rdata",    32'(bus.cpu_rdata),  32'h3C);
    chk("cr_vrv_n2",   32'(bus.vid_rvalid), 32'd0);
    next_cycle();
    chk("cr_rv_n3",    32'(bus.cpu_rvalid), 32'd0);
    chk("cr_rdata_hold", 32'(bus.cpu_rdata), 32'h3C);
    chk("cr_busy_n3",  32'(bus.busy),       32'd0);

    // Video-only read, idx 3
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 6'd3);
    chk("vr_vid_gnt", 32'(bus.vid_gnt), 32'd1);
    chk("vr_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0);
    chk("vr_mem_addr", 32'(bus.mem_addr), 32'h83);
    next_cycle();
    chk("vr_vrv",   32'(bus.vid_rvalid), 32'd1);
    chk("vr_rdata", 32'(bus.vid_rdata),  32'h71);
    chk("vr_crv",   32'(bus.cpu_rvalid), 32'd0);
    next_cycle();

    // Vector table: contention, starvation guard, idle hold, tag routing
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwdata, vecs[i].vreq, vecs[i].vidx);
      chk($sformatf("v%0d_cpu_gnt", i),    32'(bus.cpu_gnt),    32'(vecs[i].egc));
      chk($sformatf("v%0d_vid_gnt", i),    32'(bus.vid_gnt),    32'(vecs[i].egv));
      chk($sformatf("v%0d_cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(vecs[i].ecrv));
      chk($sformatf("v%0d_vid_rvalid", i), 32'(bus.vid_rvalid), 32'(vecs[i].evrv));
      next_cycle();
      chk($sformatf("v%0d_mem_addr", i),   32'(bus.mem_addr),   32'(vecs[i].eaddr));
      chk($sformatf("v%0d_mem_we", i),     32'(bus.mem_we),     32'(vecs[i].ewe));
    end

    // CPU write 0x81 <- 0xAA, then video read of idx 1 sees the new data
    drive(1'b1, 1'b1, 8'h81, 8'hAA, 1'b0, 6'd0);
    chk("wr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 6'd1);
    chk("wr_vid_gnt",   32'(bus.vid_gnt),   32'd1);
    chk("wr_mem_we_n1", 32'(bus.mem_we),    32'd1);
    chk("wr_mem_addr",  32'(bus.mem_addr),  32'h81);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'hAA);
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0);
    chk("wr_mem_we_n2",  32'(bus.mem_we),   32'd0);
    chk("wr_rd_addr",    32'(bus.mem_addr), 32'h81);
    next_cycle();
    chk("wr_mem_we_n3",  32'(bus.mem_we),     32'd0);
    chk("wr_vid_rvalid", 32'(bus.vid_rvalid), 32'd1);
    chk("wr_vid_rdata",  32'(bus.vid_rdata),  32'hAA);
    chk("wr_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    next_cycle();

    // CPU read granted, then reset pulsed in the following cycle
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 6'd0);
    chk("mr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 6'd4);
    chk("mr_cpu_gnt_rst", 32'(bus.cpu_gnt),    32'd0);
    chk("mr_vid_gnt_rst", 32'(bus.vid_gnt),    32'd0);
    chk("mr_mem_addr",    32'(bus.mem_addr),   32'd0);
    chk("mr_mem_we",      32'(bus.mem_we),     32'd0);
    chk("mr_mem_wdata",   32'(bus.mem_wdata),  32'd0);
    chk("mr_cpu_rdata",   32'(bus.cpu_rdata),  32'd0);
    chk("mr_busy",        32'(bus.busy),       32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0);
    reset = 1'b0;
    next_cycle();
    chk("mr_cpu_rvalid_n2", 32'(bus.cpu_rvalid), 32'd0);
    chk("mr_vid_rvalid_n2", 32'(bus.vid_rvalid), 32'd0);
    chk("mr_busy_n2",       32'(bus.busy),       32'd0);

    // Arbitration after reset: starvation count starts from zero
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 6'd3);
    chk("ar_vid_gnt", 32'(bus.vid_gnt), 32'd1);
    chk("ar_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 6'd0);
    chk("ar_cpu_gnt2", 32'(bus.cpu_gnt), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0);
    chk("ar_vid_rvalid", 32'(bus.vid_rvalid), 32'd1);
    chk("ar_vid_rdata",  32'(bus.vid_rdata),  32'h71);
    next_cycle();
    chk("ar_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("ar_cpu_rdata",  32'(bus.cpu_rdata),  32'h3C);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
